// File: rtl/uart_status_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even parity, STOP_BITS stop bits.
// Optional parity bit is enabled by defining TX_PARITY_EN.
module uart_status_transmitter #(
  parameter int unsigned DIV_DEFAULT = 434,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] BC,
  input  logic [7:0] DataIn,
  input  logic       Tx_valid,
  output logic       Tx_ready,
  output logic       Tx_out,
  output logic       Tx_busy,
  output logic       Tx_done
);

  localparam int unsigned DIV_MAX = (DIV_DEFAULT > 217) ? DIV_DEFAULT : 217;
  localparam int unsigned CNT_W   = $clog2(DIV_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] last, last_n;
  logic [CNT_W-1:0] div_sel;
  logic [2:0]       idx, idx_n;
  logic             stop_idx, stop_idx_n;
  logic [7:0]       data, data_n;
  logic             out_n, ready_n, busy_n, done_n;
  logic             wrap;

  // Terminal count (DIV-1) for the selected baud rate
  always_comb begin
    case (BC)
      3'b001:  div_sel = CNT_W'(216);
      3'b010:  div_sel = CNT_W'(108);
      3'b011:  div_sel = CNT_W'(71);
      3'b100:  div_sel = CNT_W'(35);
      default: div_sel = CNT_W'(DIV_DEFAULT - 1);
    endcase
  end

  assign wrap = (cnt == last);

  // Next-state and registered-output logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_n     = last;
    idx_n      = idx;
    stop_idx_n = stop_idx;
    data_n     = data;
    out_n      = Tx_out;
    ready_n    = Tx_ready;
    busy_n     = Tx_busy;
    done_n     = 1'b0;

    if (state != IDLE) begin
      cnt_n = wrap ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        out_n   = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (Tx_valid && Tx_ready) begin
          state_n = START;
          cnt_n   = '0;
          last_n  = div_sel;
          data_n  = DataIn;
          out_n   = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (wrap) begin
          state_n = DATA;
          idx_n   = 3'd0;
          out_n   = data[0];
        end
      end

      DATA: begin
        if (wrap) begin
          if (idx == 3'd7) begin
`ifdef TX_PARITY_EN
            state_n = PARITY;
            out_n   = ^data;
`else
            state_n    = STOP;
            stop_idx_n = 1'b0;
            out_n      = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
            out_n = data[idx + 3'd1];
          end
        end
      end

      PARITY: begin
        if (wrap) begin
          state_n    = STOP;
          stop_idx_n = 1'b0;
          out_n      = 1'b1;
        end
      end

      STOP: begin
        if (wrap) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_n = IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        out_n   = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= '0;
      idx      <= 3'd0;
      stop_idx <= 1'b0;
      data     <= 8'h00;
      Tx_out   <= 1'b1;
      Tx_ready <= 1'b1;
      Tx_busy  <= 1'b0;
      Tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      idx      <= idx_n;
      stop_idx <= stop_idx_n;
      data     <= data_n;
      Tx_out   <= out_n;
      Tx_ready <= ready_n;
      Tx_busy  <= busy_n;
      Tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_status_transmitter.sv
// Scoreboard bench for uart_status_transmitter: stimulus queues expected frames, a monitor
// decodes the serial line cycle by cycle and checks every bit, the end-of-frame pulse and gaps.
module tb_uart_status_transmitter;

  localparam int unsigned STOP_BITS = 1;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR + int'(STOP_BITS) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] bc = 3'b000;
  logic [7:0] data_in = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_out, tx_busy, tx_done;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit mon_active = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       par;
    int         gap;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];

  uart_status_transmitter #(.DIV_DEFAULT(434), .STOP_BITS(STOP_BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .BC       (bc),
    .DataIn   (data_in),
    .Tx_valid (tx_valid),
    .Tx_ready (tx_ready),
    .Tx_out   (tx_out),
    .Tx_busy  (tx_busy),
    .Tx_done  (tx_done)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input string info);
    n_checks++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  // Offer a byte and queue the frame expected for it once it is about to be accepted
  task automatic send(input logic [7:0] d, input logic [2:0] sel, input int div,
                      input logic par, input int gap, input bit abort, input bit hold);
    exp_t e;
    int n = 0;
    @(negedge clk);
    data_in  = d;
    bc       = sel;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      check("accept", 1'b0, $sformatf("byte %02h not accepted after %0d cycles, required ready", d, n));
      tx_valid = 1'b0;
    end else begin
      e = '{data: d, div: div, par: par, gap: gap, abort: abort};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mon_active || exp_q.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mon_active || exp_q.size() != 0 || tx_busy !== 1'b0)
      check("idle_timeout", 1'b0, $sformatf("still busy after %0d cycles, queue=%0d, required idle",
                                            n, exp_q.size()));
  endtask

  // Monitor: decode each frame against the head of the queue
  initial begin : monitor
    exp_t e;
    logic exp_bit;
    int   bad;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx_out === 1'b0) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1'b0, $sformatf("start bit at cycle %0d, required no frame", cyc));
          while (!reset && tx_busy === 1'b1) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          if (e.gap > 0)
            check("frame_gap", (cyc - (last_done_cyc - 1)) == e.gap,
                  $sformatf("start %0d cycles after last stop cycle, required %0d",
                            cyc - (last_done_cyc - 1), e.gap));
          aborted = 1'b0;
          for (int b = 0; b < NBITS && !aborted; b++) begin
            if (b == 0)                      exp_bit = 1'b0;
            else if (b <= 8)                 exp_bit = e.data[b-1];
            else if (b == 9 && PAR == 1)     exp_bit = e.par;
            else                             exp_bit = 1'b1;
            bad = 0;
            for (int c = 0; c < e.div; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (reset) begin
                aborted = 1'b1;
                break;
              end
              if (tx_out !== exp_bit || tx_busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0)
                bad++;
            end
            if (!aborted)
              check($sformatf("bit%0d_byte%02h", b, e.data), bad == 0,
                    $sformatf("%0d bad cycles of %0d, required 0 (line %b busy 1 ready 0 done 0)",
                              bad, e.div, exp_bit));
          end
          if (aborted) begin
            check("abort", e.abort, $sformatf("byte %02h frame cut by reset, required full frame", e.data));
            while (reset) @(negedge clk);
          end else begin
            if (e.abort)
              check("abort", 1'b0, $sformatf("byte %02h frame completed, required reset abort", e.data));
            @(negedge clk);
            check($sformatf("done_byte%02h", e.data), {tx_done, tx_ready, tx_busy, tx_out} === 4'b1101,
                  $sformatf("done/ready/busy/out=%b, required 1101",
                            {tx_done, tx_ready, tx_busy, tx_out}));
            last_done_cyc = cyc;
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : stim
    int bad;
    repeat (5) @(negedge clk);
    check("reset_state", {tx_out, tx_ready, tx_busy, tx_done} === 4'b1100,
          $sformatf("out/ready/busy/done=%b, required 1100", {tx_out, tx_ready, tx_busy, tx_done}));
    reset = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({tx_out, tx_ready, tx_busy, tx_done} !== 4'b1100) bad++;
    end
    check("idle_1000", bad == 0, $sformatf("%0d non-idle cycles, required 0", bad));

    // Default rate
    send(8'hA5, 3'b000, 434, 1'b0, 0, 1'b0, 1'b0);
    wait_idle(10000);

    // Rate table, with a stray valid while busy that must be ignored
    send(8'h01, 3'b100, 36, 1'b1, 0, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    data_in  = 8'hEE;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(2000);
    send(8'h01, 3'b001, 217, 1'b1, 0, 1'b0, 1'b0);
    wait_idle(5000);
    send(8'h01, 3'b010, 109, 1'b1, 0, 1'b0, 1'b0);
    wait_idle(3000);
    send(8'h01, 3'b011, 72, 1'b1, 0, 1'b0, 1'b0);
    wait_idle(2000);
    send(8'h80, 3'b111, 434, 1'b1, 0, 1'b0, 1'b0);
    wait_idle(10000);

    // Back-to-back with valid held high
    send(8'h55, 3'b000, 434, 1'b0, 0, 1'b0, 1'b1);
    send(8'hFF, 3'b000, 434, 1'b0, 2, 1'b0, 1'b0);
    wait_idle(10000);

    // BC and DataIn change during data bit 3
    send(8'hC3, 3'b000, 434, 1'b0, 0, 1'b0, 1'b0);
    repeat (4 * 434 + 200) @(negedge clk);
    bc      = 3'b100;
    data_in = 8'h00;
    wait_idle(10000);

    // Reset during data bit 5, then a clean frame
    send(8'h96, 3'b100, 36, 1'b0, 0, 1'b1, 1'b0);
    repeat (6 * 36 + 18) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_async", {tx_out, tx_busy, tx_ready} === 3'b101,
          $sformatf("out/busy/ready=%b right after reset, required 101", {tx_out, tx_busy, tx_ready}));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send(8'h3C, 3'b100, 36, 1'b0, 0, 1'b0, 1'b0);
    wait_idle(2000);

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation exceeded 5 ms, required completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_status_transmitter.md
Name: uart_status_transmitter

Overview:
- Serial UART transmitter for the motor-controller FPGA; sends bytes (hall-sensor snapshots, fault codes, acknowledgements) back to the host on Tx_out.
- It is the opposite end of the controller's UART receive path and uses the same 3-bit baud selection BC, so both directions run at the same rate.
- Frame: 1 start bit, 8 data bits LSB-first, optional even parity bit, STOP_BITS stop bits. Line idles high.
- Byte-level valid/ready handshake with a single-entry holding register.

Parameters:
- DIV_DEFAULT, 434, bit period in clk cycles when BC selects the default rate (115200 baud at 50 MHz).
- STOP_BITS, 1, number of stop bits per frame; legal values are 1 or 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- BC  input  3  baud select; sampled only at frame acceptance.
- DataIn  input  8  byte to transmit.
- Tx_valid  input  1  DataIn is valid.
- Tx_ready  output  1  transmitter can accept a byte.
- Tx_out  output  1  serial line, idle high.
- Tx_busy  output  1  high while a frame is in progress.
- Tx_done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (async, active-high) forces: Tx_out=1, Tx_ready=1, Tx_busy=0, Tx_done=0, FSM=IDLE, counters=0. The in-flight frame is discarded.
- Divisor DIV is decoded from BC:
  - 3'b001 -> 217
  - 3'b010 -> 109
  - 3'b011 -> 72
  - 3'b100 -> 36
  - any other value -> DIV_DEFAULT
- DIV and DataIn are latched at acceptance. Changes to BC or DataIn mid-frame have no effect.
- Handshake:
  - A byte is accepted on the rising clk edge where Tx_valid=1 and Tx_ready=1.
  - Tx_ready=1 only in IDLE. It drops the cycle after acceptance.
  - Tx_valid asserted while Tx_ready=0 is ignored; no queuing beyond the holding register.
- FSM states and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA.
  - DATA (bit index 0..7) -> PARITY if TX_PARITY_EN is defined, otherwise -> STOP.
  - PARITY -> STOP.
  - STOP (STOP_BITS bit periods) -> IDLE.
- Timing:
  - Tx_out goes low on the first cycle after acceptance (latency 1 clk).
  - Every bit, start and stop included, is held exactly DIV clk cycles. The baud counter counts 0..DIV-1 and wraps on the bit boundary.
  - The data bit index advances at each wrap. Leaving DATA happens on the wrap after index 7.
- Tx_busy=1 from the cycle after acceptance through the last stop-bit cycle.
- Tx_done pulses high for exactly one cycle, on the cycle the FSM re-enters IDLE. Tx_ready is 1 in that same cycle.
- Back-to-back operation:
  - If Tx_valid is held high, the next byte is accepted in the Tx_done cycle.
  - Minimum gap between frames is 1 clk of idle-high.
  - Frame length is (10 + P + STOP_BITS - 1) * DIV cycles, where P=1 with parity and P=0 without.
- Tx_out is registered (no glitches).
- Reset asserted mid-frame: Tx_out returns high immediately (asynchronously). After release, the FSM restarts from IDLE.
- Tx_out, Tx_ready, Tx_busy and Tx_done are registered outputs.

Optional Feature:
- Macro: TX_PARITY_EN.
- When defined: a PARITY state is inserted after the data bits, lasting one bit period. Tx_out = XOR of the 8 latched data bits (even parity, matching the receiver's parity checker).
- When undefined: no parity bit; DATA goes directly to STOP, and the frame is one bit period shorter.

Test Plan:
- Reset and idle: hold reset high, then release with no Tx_valid -> Tx_out=1, Tx_ready=1, Tx_busy=0 for 1000 cycles.
- Single byte, default rate: BC=3'b000, DataIn=8'hA5, one-cycle Tx_valid.
  - Tx_out low 434 cycles, then bits 1,0,1,0,0,1,0,1 at 434 cycles each.
  - With TX_PARITY_EN: parity bit 0.
  - Stop bit high 434 cycles, then Tx_done pulse, Tx_ready=1.
- Rate table: BC=3'b100, DataIn=8'h01 -> every bit 36 cycles. Repeat with BC=3'b001/010/011 -> 217/109/72 cycles per bit.
- Back-to-back: Tx_valid held high with bytes 8'h55 then 8'hFF -> second start bit begins exactly 2 cycles after the last stop-bit cycle of the first frame. Parity bit for 8'hFF is 0 when enabled.
- Mid-frame changes: change BC from 3'b000 to 3'b100 and DataIn to 8'h00 during data bit 3 of 8'hC3 -> the frame completes at 434 cycles per bit carrying 8'hC3.
- Reset mid-frame: assert reset during data bit 5 -> Tx_out=1 and Tx_busy=0 in the same cycle. After release, a new byte 8'h3C transmits correctly.
